// File: rtl/zet_umi_arbiter.sv
// Two-master UMI arbiter: exec port has priority, fetch is forced through after
// STARVE_LIMIT consecutive exec grants taken while fetch was waiting.
module zet_umi_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CW           = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] f_adr_i,
   input  logic        f_by_i,
   input  logic        f_stb_i,
   output logic [15:0] f_dat_o,
   output logic        f_ack_o,
   input  logic [19:0] e_adr_i,
   input  logic [15:0] e_dat_i,
   input  logic        e_we_i,
   input  logic        e_by_i,
   input  logic        e_tga_i,
   input  logic        e_stb_i,
   output logic [15:0] e_dat_o,
   output logic        e_ack_o,
   output logic [19:0] s_adr_o,
   output logic [15:0] s_dat_o,
   output logic        s_we_o,
   output logic        s_by_o,
   output logic        s_tga_o,
   output logic        s_stb_o,
   input  logic [15:0] s_dat_i,
   input  logic        s_ack_i,
   output logic [1:0]  gnt_o
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GF   = 2'b01,
      GE   = 2'b10
   } state_t;

   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   state_t        state_r;
   state_t        cur_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_inc_s;
   logic          fetch_forced_s;

   assign cnt_inc_s      = (cnt_r >= LIMIT) ? LIMIT : cnt_r + {{(CW-1){1'b0}}, 1'b1};
   assign fetch_forced_s = f_stb_i && (cnt_r >= LIMIT);

   // Read data is broadcast; each master qualifies it with its own ack.
   assign f_dat_o = s_dat_i;
   assign e_dat_o = s_dat_i;

   // Arbitration state and starvation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= {CW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (e_stb_i && !fetch_forced_s) begin
                  state_r <= GE;
                  cnt_r   <= f_stb_i ? cnt_inc_s : {CW{1'b0}};
               end else if (f_stb_i) begin
                  state_r <= GF;
                  cnt_r   <= {CW{1'b0}};
               end else begin
                  state_r <= IDLE;
                  cnt_r   <= cnt_r;
               end
            end
            // An ack or an abort always ends the grant; the next cycle is IDLE.
            GF: begin
               if (s_ack_i || !f_stb_i) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= GF;
               end
            end
            GE: begin
               if (s_ack_i || !e_stb_i) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= GE;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= {CW{1'b0}};
            end
         endcase
      end
   end

   // Slave-side mux; reset masks the state so an ack in the reset cycle is dropped.
   always_comb begin
      cur_s   = rst ? IDLE : state_r;
      s_adr_o = 20'h00000;
      s_dat_o = 16'h0000;
      s_we_o  = 1'b0;
      s_by_o  = 1'b0;
      s_tga_o = 1'b0;
      s_stb_o = 1'b0;
      f_ack_o = 1'b0;
      e_ack_o = 1'b0;
      gnt_o   = 2'b00;
      case (cur_s)
         GF: begin
            s_adr_o = f_adr_i;
            s_by_o  = f_by_i;
            s_stb_o = f_stb_i;
            f_ack_o = s_ack_i && f_stb_i;
            gnt_o   = 2'b01;
         end
         GE: begin
            s_adr_o = e_adr_i;
            s_dat_o = e_dat_i;
            s_we_o  = e_we_i;
            s_by_o  = e_by_i;
            s_tga_o = e_tga_i;
            s_stb_o = e_stb_i;
            e_ack_o = s_ack_i && e_stb_i;
            gnt_o   = 2'b10;
         end
         IDLE: begin
            gnt_o = 2'b00;
         end
         default: begin
            gnt_o = 2'b00;
         end
      endcase
   end

endmodule

// File: tb/tb_zet_umi_arbiter.sv
// Scenario bench for zet_umi_arbiter: expected grants and read data are queued
// when stimulus is driven and consumed when the DUT grants or acknowledges.
module tb_zet_umi_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [19:0] f_adr_i = 20'h0, e_adr_i = 20'h0, s_adr_o;
   logic        f_by_i = 1'b0, f_stb_i = 1'b0, f_ack_o;
   logic [15:0] f_dat_o, e_dat_i = 16'h0, e_dat_o, s_dat_o, s_dat_i = 16'h0;
   logic        e_we_i = 1'b0, e_by_i = 1'b0, e_tga_i = 1'b0, e_stb_i = 1'b0, e_ack_o;
   logic        s_we_o, s_by_o, s_tga_o, s_stb_o, s_ack_i = 1'b0;
   logic [1:0]  gnt_o;

   int checks = 0;
   int errors = 0;
   logic [16:0] exp_q[$];   // {is_exec, read data}
   logic [1:0]  gnt_q[$];

   zet_umi_arbiter #(.STARVE_LIMIT(4), .CW(4)) dut (
      .clk(clk), .rst(rst),
      .f_adr_i(f_adr_i), .f_by_i(f_by_i), .f_stb_i(f_stb_i), .f_dat_o(f_dat_o), .f_ack_o(f_ack_o),
      .e_adr_i(e_adr_i), .e_dat_i(e_dat_i), .e_we_i(e_we_i), .e_by_i(e_by_i), .e_tga_i(e_tga_i),
      .e_stb_i(e_stb_i), .e_dat_o(e_dat_o), .e_ack_o(e_ack_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_by_o(s_by_o), .s_tga_o(s_tga_o),
      .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [46:0] outs;
      rst = 1'b1; f_stb_i = 1'b1; e_stb_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         outs = {s_stb_o, s_we_o, s_tga_o, s_adr_o, s_dat_o, s_by_o, f_ack_o, e_ack_o, gnt_o};
         checks++;
         if (outs !== 47'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
         end
      end
      tick(); rst = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b10 || s_stb_o !== 1'b1) begin
         errors++; $display("FAIL reset_release_grant: got gnt=%b stb=%b expected gnt=10 stb=1", gnt_o, s_stb_o);
      end
      tick(); f_stb_i = 1'b0; e_stb_i = 1'b0;
      @(negedge clk);
      checks++;
      if (s_stb_o !== 1'b0) begin
         errors++; $display("FAIL reset_abort_stb: got %b expected 0", s_stb_o);
      end
      tick();
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b00) begin
         errors++; $display("FAIL reset_back_idle: got %b expected 00", gnt_o);
      end
   endtask

   task automatic test_fetch();
      logic [16:0] e;
      tick(); f_adr_i = 20'h0FFF0; f_by_i = 1'b0; f_stb_i = 1'b1; s_dat_i = 16'hEA5B;
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b00 || s_stb_o !== 1'b0) begin
         errors++; $display("FAIL fetch_latency: got gnt=%b stb=%b expected 00/0", gnt_o, s_stb_o);
      end
      tick();
      exp_q.push_back({1'b0, 16'hEA5B});
      for (int g = 0; g < 3; g++) begin
         s_ack_i = (g == 2);
         @(negedge clk);
         checks++;
         if (gnt_o !== 2'b01 || s_stb_o !== 1'b1 || s_adr_o !== 20'h0FFF0 || s_we_o !== 1'b0 || e_ack_o !== 1'b0) begin
            errors++; $display("FAIL fetch_drive: got gnt=%b stb=%b adr=%h we=%b eack=%b expected 01/1/0fff0/0/0",
                               gnt_o, s_stb_o, s_adr_o, s_we_o, e_ack_o);
         end
         checks++;
         if (f_ack_o !== (g == 2)) begin
            errors++; $display("FAIL fetch_ack: cycle %0d got %b expected %b", g, f_ack_o, (g == 2));
         end
         if (f_ack_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL fetch_sb: got unexpected ack expected none");
            end else begin
               e = exp_q.pop_front();
               if ({1'b0, f_dat_o} !== e) begin
                  errors++; $display("FAIL fetch_data: got %h expected %h", {1'b0, f_dat_o}, e);
               end
            end
         end
         tick();
      end
      s_ack_i = 1'b0; f_stb_i = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b00 || f_ack_o !== 1'b0 || exp_q.size() != 0) begin
         errors++; $display("FAIL fetch_idle_after: got gnt=%b ack=%b q=%0d expected 00/0/0", gnt_o, f_ack_o, exp_q.size());
      end
   endtask

   task automatic test_exec_write();
      logic [16:0] e;
      tick(); e_adr_i = 20'h003F8; e_dat_i = 16'h00AA; e_we_i = 1'b1; e_tga_i = 1'b1; e_stb_i = 1'b1;
      s_dat_i = 16'h1234;
      tick();
      exp_q.push_back({1'b1, 16'h1234});
      for (int g = 0; g < 2; g++) begin
         s_ack_i = (g == 1);
         @(negedge clk);
         checks++;
         if ({gnt_o, s_stb_o, s_we_o, s_tga_o, s_adr_o, s_dat_o} !== {2'b10, 3'b111, 20'h003F8, 16'h00AA}) begin
            errors++; $display("FAIL exec_drive: got gnt=%b stb=%b we=%b tga=%b adr=%h dat=%h expected 10/1/1/1/003f8/00aa",
                               gnt_o, s_stb_o, s_we_o, s_tga_o, s_adr_o, s_dat_o);
         end
         checks++;
         if (e_ack_o !== (g == 1) || f_ack_o !== 1'b0) begin
            errors++; $display("FAIL exec_ack: got e=%b f=%b expected e=%b f=0", e_ack_o, f_ack_o, (g == 1));
         end
         if (e_ack_o === 1'b1) begin
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h0;
            if ({1'b1, e_dat_o} !== e) begin
               errors++; $display("FAIL exec_data: got %h expected %h", {1'b1, e_dat_o}, e);
            end
         end
         tick();
      end
      s_ack_i = 1'b0; e_stb_i = 1'b0; e_we_i = 1'b0; e_tga_i = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b00 || exp_q.size() != 0) begin
         errors++; $display("FAIL exec_idle_after: got gnt=%b q=%0d expected 00/0", gnt_o, exp_q.size());
      end
   endtask

   task automatic test_starvation();
      logic [1:0] e;
      int budget;
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 4; j++) gnt_q.push_back(2'b10);
         gnt_q.push_back(2'b01);
      end
      tick(); f_stb_i = 1'b1; e_stb_i = 1'b1; f_adr_i = 20'h00100; e_adr_i = 20'h00200;
      budget = 0;
      while (gnt_q.size() != 0 && budget < 60) begin
         tick();
         budget++;
         s_ack_i = (gnt_o != 2'b00);
         @(negedge clk);
         if (gnt_o != 2'b00) begin
            e = gnt_q.pop_front();
            checks++;
            if (gnt_o !== e) begin
               errors++; $display("FAIL starve_order: grant %0d got %b expected %b", 10 - gnt_q.size(), gnt_o, e);
            end
            checks++;
            if ({f_ack_o, e_ack_o} !== {gnt_o[0], gnt_o[1]}) begin
               errors++; $display("FAIL starve_ack_route: got f=%b e=%b for gnt %b", f_ack_o, e_ack_o, gnt_o);
            end
         end
      end
      checks++;
      if (gnt_q.size() != 0) begin
         errors++; $display("FAIL starve_timeout: got %0d grants left expected 0", gnt_q.size());
         gnt_q.delete();
      end
      tick(); f_stb_i = 1'b0; e_stb_i = 1'b0; s_ack_i = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b00) begin
         errors++; $display("FAIL starve_idle_after: got %b expected 00", gnt_o);
      end
   endtask

   task automatic test_back_to_back();
      tick(); e_stb_i = 1'b1;
      tick();
      s_ack_i = 1'b1; f_stb_i = 1'b1;
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b10 || e_ack_o !== 1'b1) begin
         errors++; $display("FAIL b2b_exec_ack: got gnt=%b ack=%b expected 10/1", gnt_o, e_ack_o);
      end
      tick(); e_stb_i = 1'b0; s_ack_i = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b00 || s_stb_o !== 1'b0) begin
         errors++; $display("FAIL b2b_idle_gap: got gnt=%b stb=%b expected 00/0", gnt_o, s_stb_o);
      end
      tick(); s_ack_i = 1'b1;
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b01 || f_ack_o !== 1'b1) begin
         errors++; $display("FAIL b2b_fetch_grant: got gnt=%b ack=%b expected 01/1", gnt_o, f_ack_o);
      end
      tick(); f_stb_i = 1'b0; s_ack_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_abort();
      tick(); e_stb_i = 1'b1; e_we_i = 1'b1;
      tick();
      @(negedge clk);
      e_stb_i = 1'b0;
      #1;
      checks++;
      if (s_stb_o !== 1'b0 || e_ack_o !== 1'b0 || gnt_o !== 2'b10) begin
         errors++; $display("FAIL abort_same_cycle: got stb=%b ack=%b gnt=%b expected 0/0/10", s_stb_o, e_ack_o, gnt_o);
      end
      tick(); s_ack_i = 1'b1;
      @(negedge clk);
      checks++;
      if ({gnt_o, s_stb_o, e_ack_o, f_ack_o} !== 5'b00000) begin
         errors++; $display("FAIL abort_late_ack: got gnt=%b stb=%b e=%b f=%b expected all 0", gnt_o, s_stb_o, e_ack_o, f_ack_o);
      end
      tick(); s_ack_i = 1'b0; e_we_i = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b00) begin
         errors++; $display("FAIL abort_idle_ack: got %b expected 00", gnt_o);
      end
   endtask

   task automatic test_reset_mid();
      tick(); f_stb_i = 1'b1;
      tick();
      rst = 1'b1; s_ack_i = 1'b1;
      @(negedge clk);
      checks++;
      if (f_ack_o !== 1'b0 || gnt_o !== 2'b00 || s_stb_o !== 1'b0) begin
         errors++; $display("FAIL rst_mid_ack: got ack=%b gnt=%b stb=%b expected 0/00/0", f_ack_o, gnt_o, s_stb_o);
      end
      tick(); rst = 1'b0; s_ack_i = 1'b0; f_stb_i = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b00) begin
         errors++; $display("FAIL rst_mid_idle: got %b expected 00", gnt_o);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_exec_write();
      test_starvation();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/zet_umi_arbiter.md
Name: zet_umi_arbiter

Overview:
- Two-master, one-slave arbiter for the UMI memory bus.
- Lets the prefetch front-end (fetch port, read-only) and the execution back-end (exec port, read/write) share a single UMI slave: memory controller or bus bridge.
- Sits between the core's two UMI master ports and the system memory interface.
- Exec has priority; a bounded starvation counter guarantees fetch forward progress.

Parameters:
STARVE_LIMIT, 4, consecutive exec grants allowed while fetch is pending before fetch is forced through (1..15)
CW, 4, width of the starvation counter; must satisfy 2^CW > STARVE_LIMIT

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
f_adr_i  in  20  fetch address
f_by_i  in  1  fetch byte access
f_stb_i  in  1  fetch strobe (request)
f_dat_o  out  16  fetch read data
f_ack_o  out  1  fetch acknowledge
e_adr_i  in  20  exec address
e_dat_i  in  16  exec write data
e_we_i  in  1  exec write enable
e_by_i  in  1  exec byte access
e_tga_i  in  1  exec tag (I/O space)
e_stb_i  in  1  exec strobe
e_dat_o  out  16  exec read data
e_ack_o  out  1  exec acknowledge
s_adr_o  out  20  slave address
s_dat_o  out  16  slave write data
s_we_o  out  1  slave write enable
s_by_o  out  1  slave byte access
s_tga_o  out  1  slave tag
s_stb_o  out  1  slave strobe
s_dat_i  in  16  slave read data
s_ack_i  in  1  slave acknowledge
gnt_o  out  2  current grant: 00 none, 01 fetch, 10 exec

Behaviour:
- FSM states: IDLE, GF (fetch granted), GE (exec granted). Registered state; all slave-side outputs are a combinational mux on the registered state.
- Reset: state=IDLE, starvation counter=0.
- Reset-state outputs: s_stb_o=0, s_we_o=0, s_tga_o=0, s_adr_o=0, s_dat_o=0, s_by_o=0, f_ack_o=0, e_ack_o=0, gnt_o=00.
- Reset asserted mid-transfer forces IDLE next edge; an ack arriving in that cycle is not forwarded.
- IDLE arbitration, on the edge:
  - e_stb_i only -> GE.
  - f_stb_i only -> GF.
  - Both, counter < STARVE_LIMIT -> GE.
  - Both, counter == STARVE_LIMIT -> GF.
  - Neither -> stay IDLE.
- Starvation counter:
  - Increments when GE is entered while f_stb_i=1.
  - Clears when GF is entered, or when GE is entered with f_stb_i=0.
  - Saturates at STARVE_LIMIT.
- GF drive:
  - s_adr_o=f_adr_i, s_by_o=f_by_i, s_stb_o=f_stb_i.
  - s_we_o=0, s_tga_o=0, s_dat_o=0.
  - f_ack_o=s_ack_i, e_ack_o=0.
- GE drive:
  - s_adr_o, s_dat_o, s_we_o, s_by_o and s_tga_o follow the e_* inputs; s_stb_o=e_stb_i.
  - e_ack_o=s_ack_i, f_ack_o=0.
- IDLE drive: s_stb_o=0 and both acks 0; s_adr_o and the other slave-side data outputs are 0.
- Read data: f_dat_o and e_dat_o both equal s_dat_i at all times; a master qualifies it with its own ack.
- Grant hold: the grant is held until s_ack_i=1, then the FSM returns to IDLE. The cycle after any ack is always IDLE, so a master's stale stb is never mistaken for a new request.
- Latency: request seen at edge N gives s_stb_o high in cycle N+1. Minimum two cycles per transfer; back-to-back throughput is one transfer per (slave latency + 1) cycles.
- Abort: if the granted master's stb drops before ack, s_stb_o drops the same cycle and the FSM returns to IDLE. A late ack with s_stb_o=0 is ignored.
- s_ack_i while in IDLE is ignored: no ack is forwarded and the state is unchanged.
- gnt_o: 01 in GF, 10 in GE, 00 in IDLE.

Test Plan:
- Reset: hold rst 2 cycles with f_stb_i=e_stb_i=1 -> s_stb_o=0 and gnt_o=00 throughout; gnt_o=10 on the first edge after rst release.
- Fetch alone: f_stb_i=1, f_adr_i=20'h0FFF0, slave ack 2 cycles after stb with s_dat_i=16'hEA5B -> s_adr_o=0FFF0, s_we_o=0, f_ack_o pulses one cycle with f_dat_o=EA5B; the next cycle is IDLE.
- Exec write: e_stb_i=1, e_we_i=1, e_tga_i=1, e_adr_i=20'h003F8, e_dat_i=16'h00AA -> slave sees we=1, tga=1, addr 003F8, data 00AA; e_ack_o=s_ack_i, f_ack_o stays 0.
- Starvation, STARVE_LIMIT=4: both stb held high continuously with ack 1 cycle after grant -> grant order E,E,E,E,F,E,E,E,E,F.
- Simultaneous ack/new request: exec acked in cycle N while f_stb_i rises in cycle N -> cycle N+1 IDLE, cycle N+2 GF.
- Abort: grant exec, drop e_stb_i before ack, slave acks one cycle later -> s_stb_o=0 immediately, FSM in IDLE, no e_ack_o or f_ack_o pulse.
